// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_arbiter_pkg: shared FSM state type and default sizing for the multiplier-sharing arbiter
package mult_share_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam int DEF_WIDTH          = 8;
   localparam int DEF_TIMEOUT_CYCLES = 15;
endpackage

// File: rtl/mult_share_arbiter_rr_grant2.sv
// rr_grant2: two-way round-robin grant, one-hot output
//   valid : request valid bits, bit i = requester i
//   last  : index of the requester served most recently
//   grant : one-hot grant (all zero when nothing is valid)
module rr_grant2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);
   // On contention the requester that was not served last wins.
   assign grant = (valid == 2'b11) ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one external Booth multiplier between two requesters
//   Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort a WAIT that exceeds
//   TIMEOUT_CYCLES cycles (response with rsp_err=1, rsp_result=0).
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid / req_ready      : per-requester handshake (ready is one-hot, IDLE only)
//   req{0,1}_a / req{0,1}_b    : signed operands of each requester
//   rsp_valid / rsp_ready      : shared response handshake
//   rsp_id, rsp_result, rsp_err: response owner, product, watchdog abort flag
//   mul_start                  : one-cycle start strobe to the multiplier
//   mul_multiplier/multiplicand: operands held stable while the multiplier runs
//   mul_done, mul_result       : multiplier completion and product
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [2*WIDTH-1:0] rsp_result,
   output logic               rsp_err,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_multiplier,
   output logic [WIDTH-1:0]   mul_multiplicand,
   input  logic               mul_done,
   input  logic [2*WIDTH-1:0] mul_result
);
   state_t     state;
   logic       last;
   logic [1:0] grant;
   logic       gid;

   rr_grant2 u_rr_grant2 (.valid(req_valid), .last(last), .grant(grant));

   // Ready is combinational so a requester sees its grant in the same cycle;
   // gating with rst_n keeps it low while reset is asserted.
   assign req_ready = (rst_n && state == IDLE) ? grant : 2'b00;
   assign gid       = grant[1];

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_cnt;
   logic          err_q;
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         last             <= 1'b1;
         rsp_valid        <= 1'b0;
         rsp_id           <= 1'b0;
         rsp_result       <= '0;
         mul_start        <= 1'b0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
         wd_cnt           <= '0;
         err_q            <= 1'b0;
`endif
      end else begin
         mul_start <= 1'b0;
         case (state)
            IDLE: if (|grant) begin
               mul_multiplier   <= gid ? req1_a : req0_a;
               mul_multiplicand <= gid ? req1_b : req0_b;
               rsp_id           <= gid;
               last             <= gid;
               mul_start        <= 1'b1;
               state            <= ISSUE;
            end
            // mul_done may still be high from the previous product here.
            ISSUE: begin
               state <= WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
               wd_cnt <= '0;
`endif
            end
            WAIT: if (mul_done) begin
               rsp_result <= mul_result;
               rsp_valid  <= 1'b1;
               state      <= RESP;
`ifdef MULT_ARB_TIMEOUT_EN
               err_q      <= 1'b0;
            end else if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               rsp_result <= '0;
               rsp_valid  <= 1'b1;
               err_q      <= 1'b1;
               state      <= RESP;
            end else begin
               wd_cnt <= wd_cnt + 1'b1;
`endif
            end
            // Returning to IDLE (not accepting here) leaves one idle cycle after a transfer.
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench with a behavioural 8-iteration multiplier
module tb_mult_share_arbiter;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [1:0]     req_valid = 2'b00;
   logic [1:0]     req_ready;
   logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic           rsp_valid, rsp_id, rsp_err, mul_start;
   logic           rsp_ready = 1'b1;
   logic [2*W-1:0] rsp_result;
   logic [W-1:0]   mul_multiplier, mul_multiplicand;
   logic           mul_done = 1'b0;
   logic [2*W-1:0] mul_result = '0;

   int checks = 0;
   int errors = 0;
   int xfers  = 0;
   logic both_seen = 1'b0;

   mult_share_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_multiplier(mul_multiplier),
      .mul_multiplicand(mul_multiplicand),
      .mul_done(mul_done), .mul_result(mul_result)
   );

   always #5 clk = ~clk;

   // Multiplier model: start edge loads, 8 further edges iterate, done stays high until next start.
   logic         busy = 1'b0;
   logic         hang = 1'b0;
   int           cnt = 0;
   logic [W-1:0] pa = '0, pb = '0;
   always @(posedge clk) begin
      if (mul_start) begin
         busy <= 1'b1; cnt <= 0; mul_done <= 1'b0;
         pa <= mul_multiplier; pb <= mul_multiplicand;
      end else if (busy) begin
         cnt <= cnt + 1;
         if (cnt == 7) begin
            busy <= 1'b0;
            mul_done <= !hang;
            mul_result <= $signed(pa) * $signed(pb);
         end
      end
   end

   always @(negedge clk) begin
      if (req_ready == 2'b11) both_seen = 1'b1;
      if (rsp_valid && rsp_ready) xfers++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0; req_valid = 2'b00;
      @(negedge clk); rst_n = 1'b1;
   endtask

   // Counts rising edges until rsp_valid is seen; n = -1 if it never arrives.
   task automatic wait_rsp(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin n = i; break; end
      end
   endtask

   task automatic test_reset();
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, mul_start} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_id, rsp_err, mul_start}); end
      checks++;
      if ({rsp_result, mul_multiplier, mul_multiplicand} !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {rsp_result, mul_multiplier, mul_multiplicand}); end
      req_valid = 2'b00;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_single_req0();
      int n;
      @(negedge clk); req0_a = 8'd3; req0_b = 8'd2; req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
      @(posedge clk); #1; req_valid = 2'b00;
      checks++;
      if ({mul_start, mul_multiplier, mul_multiplicand} !== {1'b1, 8'd3, 8'd2}) begin errors++; $display("FAIL single_issue: got %h want 10302", {mul_start, mul_multiplier, mul_multiplicand}); end
      wait_rsp(n);
      checks++;
      if (n !== 10) begin errors++; $display("FAIL single_latency: got %0d want 10", n); end
      checks++;
      if ({rsp_id, rsp_err, rsp_result} !== {1'b0, 1'b0, 16'h0006}) begin errors++; $display("FAIL single_rsp: id/err/result got %b/%b/%h want 0/0/0006", rsp_id, rsp_err, rsp_result); end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", rsp_valid); end
   endtask

   task automatic test_req1();
      int n;
      @(negedge clk); req1_a = 8'h85; req1_b = 8'hFC; req_valid = 2'b10;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("FAIL req1_ready: got %b want 10", req_ready); end
      @(posedge clk); #1; req_valid = 2'b00;
      wait_rsp(n);
      checks++;
      if ({rsp_id, rsp_result} !== {1'b1, 16'h01EC}) begin errors++; $display("FAIL req1_rsp: id/result got %b/%h want 1/01ec", rsp_id, rsp_result); end
      @(posedge clk); #1;
   endtask

   task automatic test_both();
      int n;
      do_reset();
      both_seen = 1'b0;
      req0_a = 8'd68; req0_b = 8'd2; req1_a = 8'd11; req1_b = 8'hFF; req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL both_first_grant: got %b want 01", req_ready); end
      @(posedge clk); #1; req_valid = 2'b10;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL both_issue_ready: got %b want 00", req_ready); end
      wait_rsp(n);
      checks++;
      if ({n == 10, rsp_id, rsp_result} !== {1'b1, 1'b0, 16'h0088}) begin errors++; $display("FAIL both_rsp0: lat/id/result got %0d/%b/%h want 10/0/0088", n, rsp_id, rsp_result); end
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL both_resp_ready: got %b want 00", req_ready); end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, req_ready} !== 3'b010) begin errors++; $display("FAIL both_after_xfer: valid/ready got %b/%b want 0/10", rsp_valid, req_ready); end
      @(posedge clk); #1; req_valid = 2'b00;
      wait_rsp(n);
      checks++;
      if ({rsp_id, rsp_result} !== {1'b1, 16'hFFF5}) begin errors++; $display("FAIL both_rsp1: id/result got %b/%h want 1/fff5", rsp_id, rsp_result); end
      @(posedge clk); #1;
      checks++;
      if (both_seen !== 1'b0) begin errors++; $display("FAIL both_onehot: double grant seen got %b want 0", both_seen); end
   endtask

   task automatic test_backpressure();
      int n, x0;
      rsp_ready = 1'b0;
      @(negedge clk); req0_a = 8'd5; req0_b = 8'd7; req_valid = 2'b01;
      @(posedge clk); #1; req_valid = 2'b00;
      x0 = xfers;
      wait_rsp(n);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 16'h0023}) begin errors++; $display("FAIL bp_hold%0d: valid/id/result got %b/%b/%h want 1/0/0023", i, rsp_valid, rsp_id, rsp_result); end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b want 0", rsp_valid); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (xfers - x0 !== 1) begin errors++; $display("FAIL bp_xfers: got %0d want 1", xfers - x0); end
      req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_idle: got %b want 01", req_ready); end
      req_valid = 2'b00;
   endtask

   task automatic test_reset_mid();
      logic seen;
      @(negedge clk); req0_a = 8'd4; req0_b = 8'd4; req_valid = 2'b01;
      @(posedge clk); #1; req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, mul_start, rsp_result, mul_multiplier, mul_multiplicand, req_ready} !== '0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", {rsp_valid, rsp_id, rsp_err, mul_start, rsp_result, mul_multiplier, mul_multiplicand, req_ready}); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midreset_norsp: got %b want 0", seen); end
      @(negedge clk); req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL midreset_grant: got %b want 01", req_ready); end
      req_valid = 2'b00;
   endtask

`ifdef MULT_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      hang = 1'b1;
      @(negedge clk); req0_a = 8'd2; req0_b = 8'd2; req_valid = 2'b01;
      @(posedge clk); #1; req_valid = 2'b00;
      wait_rsp(n);
      checks++;
      if (n !== 16) begin errors++; $display("FAIL timeout_latency: got %0d want 16", n); end
      checks++;
      if ({rsp_err, rsp_result} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL timeout_rsp: err/result got %b/%h want 1/0000", rsp_err, rsp_result); end
      hang = 1'b0;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_single_req0();
      test_req1();
      test_both();
      test_backpressure();
      test_reset_mid();
`ifdef MULT_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; result width is 2*WIDTH.
REQ-002 Parameter TIMEOUT_CYCLES, default 15: watchdog limit in WAIT cycles; used only when MULT_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  signed multiplier (a) and multiplicand (b) of requesters 0 and 1.
REQ-008 rsp_valid  output  1  response valid on the shared response channel.
REQ-009 rsp_ready  input  1  response consumer ready.
REQ-010 rsp_id  output  1  index of the requester that owns the response.
REQ-011 rsp_result  output  2*WIDTH  signed product.
REQ-012 rsp_err  output  1  response aborted by the watchdog.
REQ-013 mul_start  output  1  one-cycle start strobe to the shared Booth multiplier.
REQ-014 mul_multiplier, mul_multiplicand  output  WIDTH each  operands to the multiplier.
REQ-015 mul_done, mul_result  input  1, 2*WIDTH  multiplier completion flag and product (product valid while mul_done is high).

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any req_valid bit is high, the arbiter SHALL raise req_ready for exactly one granted requester, combinationally in the same cycle.
REQ-018 Grant SHALL be round-robin: when both requesters are valid, grant the requester not served last; when only one is valid, grant that one.
REQ-019 On the rising edge where the granted valid and ready are both high, the arbiter SHALL capture that requester's a, b and id, update the last-served pointer, and go to ISSUE.
REQ-020 req_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-021 ISSUE: mul_start SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT.
REQ-022 mul_multiplier and mul_multiplicand SHALL be driven from the captured registers and held stable in ISSUE and WAIT.
REQ-023 mul_done SHALL be ignored in ISSUE, because it can still be high from the previous operation.
REQ-024 WAIT: on the first edge with mul_done high, the arbiter SHALL capture mul_result into rsp_result, clear rsp_err, and go to RESP.
REQ-025 RESP: rsp_valid, rsp_id, rsp_result and rsp_err SHALL stay high/stable until an edge with rsp_ready high; the FSM SHALL then go to IDLE and drop rsp_valid.
REQ-026 After a response transfers, no new request SHALL be accepted in that same cycle.
REQ-027 With an 8-iteration multiplier core and rsp_ready held high, rsp_valid SHALL rise on the 10th rising edge after the acceptance edge.
REQ-028 The arbiter SHALL allow only one operation in flight; it does no operand arithmetic and passes products through unmodified.

Reset
REQ-029 When rst_n is low, the following SHALL be forced asynchronously, including mid-operation: state = IDLE; last-served pointer = 1 (so requester 0 wins first); req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, mul_start, mul_multiplier and mul_multiplicand = 0; watchdog counter = 0.
REQ-030 An operation interrupted by reset SHALL be discarded, with no response generated.

Configuration
REQ-031 With macro MULT_ARB_TIMEOUT_EN defined:
- a counter SHALL run in WAIT;
- if mul_done has not been seen after TIMEOUT_CYCLES WAIT cycles, the FSM SHALL go to RESP with rsp_err = 1 and rsp_result = 0.
REQ-032 Without MULT_ARB_TIMEOUT_EN:
- no counter SHALL exist;
- rsp_err SHALL be tied to 0;
- WAIT SHALL last until mul_done.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration (IDLE/ISSUE/WAIT/RESP) and the default WIDTH and TIMEOUT_CYCLES constants.
REQ-034 The round-robin grant logic SHALL be one sub-module, rr_grant2, that takes the valid bits and last-served pointer and produces a one-hot grant.
REQ-035 The multiplier SHALL stay external and be connected by the bench/top level.

Verification
REQ-036 Req0 a=3, b=2 alone -> req_ready[0] high in the same cycle; rsp_id=0; rsp_result=16'h0006 on the 10th edge after acceptance.
REQ-037 Req1 a=8'h85 (-123), b=8'hFC (-4) -> rsp_id=1; rsp_result=16'h01EC (492).
REQ-038 Both requesters valid right after reset, with 68*2 on req0 and 11*-1 on req1 -> first response id=0 with 16'h0088, second id=1 with 16'hFFF5; req_ready never high for both at once.
REQ-039 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result held unchanged; exactly one transfer, then return to IDLE.
REQ-040 rst_n pulsed low during WAIT -> all outputs 0 immediately; no response; the next request is granted to requester 0.
REQ-041 With MULT_ARB_TIMEOUT_EN defined and mul_done tied low -> RESP after 15 WAIT cycles with rsp_err=1 and rsp_result=0.
